// File: rtl/jt89_writer.sv
// jt89_writer: host-side bus master for the jt89 PSG register port.
//
// Register-update commands (register number + value) are queued in a small
// FIFO and serialised into PSG byte writes: a latch byte, then a data byte
// for tone registers. Consecutive strobes are spaced by at least GAP clken
// pulses so the PSG can be programmed without hand-timing.
//
// Optional feature macro: JT89_WR_SKIP_EN
//   When defined, shadow copies of the PSG registers suppress redundant
//   writes (whole command, or just the tone data byte). Noise-control writes
//   are never suppressed because they restart the noise LFSR.
//
// Ports:
//   clk        clock
//   rst        synchronous reset, active-high
//   clken      PSG clock enable; only advances the gap counter
//   cmd_valid  command offered
//   cmd_ready  FIFO can accept a command (!full)
//   cmd_reg    PSG register: 000/010/100 tone0-2, 001/011/101/111 vol0-3, 110 noise
//   cmd_data   value; tone [9:0], volume [3:0], noise ctrl [2:0]
//   wr_n       active-low write strobe, one clk wide
//   dout       byte to PSG din, held between strobes
//   busy       FIFO non-empty or FSM not idle
module jt89_writer #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned GAP   = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clken,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [2:0] cmd_reg,
    input  logic [9:0] cmd_data,
    output logic       wr_n,
    output logic [7:0] dout,
    output logic       busy
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(GAP + 1);
    localparam logic [CW-1:0] GapLast = CW'(GAP);
    localparam logic [CW-1:0] CntOne  = CW'(1);
    localparam logic [AW:0]   PtrOne  = (AW + 1)'(1);

    typedef enum logic [2:0] {StIdle, StLatch, StWait1, StData, StWait2} state_e;

    state_e        state_q, state_d;
    logic [12:0]   mem_q [DEPTH];
    logic [AW:0]   wptr_q, rptr_q;
    logic          empty, full, push, pop;
    logic [12:0]   head, hold_q, hold_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          cnt_done;
    logic          wr_n_q, wr_n_d;
    logic [7:0]    dout_q, dout_d;
    logic          drop, skip_data;

    function automatic logic is_tone(input logic [2:0] r);
        return !r[0] && (r != 3'b110);
    endfunction

    function automatic logic [3:0] nibble(input logic [12:0] c);
        return (c[12:10] == 3'b110) ? {1'b0, c[2:0]} : c[3:0];
    endfunction

    function automatic logic [7:0] latch_byte(input logic [12:0] c);
        return {1'b1, c[12:10], nibble(c)};
    endfunction

    function automatic logic [7:0] data_byte(input logic [12:0] c);
        return {2'b00, c[9:4]};
    endfunction

    // FIFO: pointers carry one extra bit to tell full from empty.
    assign empty     = (wptr_q == rptr_q);
    assign full      = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign push      = cmd_valid && !full;
    assign cmd_ready = !full;
    assign head      = mem_q[rptr_q[AW-1:0]];
    assign busy      = !empty || (state_q != StIdle);
    assign cnt_done  = clken && ((cnt_q + CntOne) == GapLast);
    assign wr_n      = wr_n_q;
    assign dout      = dout_q;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wptr_q[AW-1:0]] <= {cmd_reg, cmd_data};
        end
    end

    // State register (plus datapath registers that follow it).
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            wptr_q  <= '0;
            rptr_q  <= '0;
            hold_q  <= '0;
            cnt_q   <= '0;
            wr_n_q  <= 1'b1;
            dout_q  <= 8'h00;
        end else begin
            state_q <= state_d;
            if (push) wptr_q <= wptr_q + PtrOne;
            if (pop)  rptr_q <= rptr_q + PtrOne;
            hold_q  <= hold_d;
            cnt_q   <= cnt_d;
            wr_n_q  <= wr_n_d;
            dout_q  <= dout_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hold_d  = hold_q;
        pop     = 1'b0;
        case (state_q)
            StIdle: begin
                if (!empty) begin
                    pop    = 1'b1;
                    hold_d = head;
                    // A dropped command is consumed without leaving idle.
                    if (!drop) state_d = StLatch;
                end
            end
            StLatch: begin
                cnt_d   = '0;
                state_d = StWait1;
            end
            StWait1: begin
                if (clken) cnt_d = cnt_q + CntOne;
                if (cnt_done) begin
                    state_d = (is_tone(hold_q[12:10]) && !skip_data) ? StData : StIdle;
                end
            end
            StData: begin
                cnt_d   = '0;
                state_d = StWait2;
            end
            StWait2: begin
                if (clken) cnt_d = cnt_q + CntOne;
                if (cnt_done) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs are registered from the next state so the strobe is glitch-free.
    always_comb begin
        wr_n_d = 1'b1;
        dout_d = dout_q;
        case (state_d)
            StLatch: begin
                wr_n_d = 1'b0;
                dout_d = latch_byte(hold_d);
            end
            StData: begin
                wr_n_d = 1'b0;
                dout_d = data_byte(hold_q);
            end
            default: ;
        endcase
    end

`ifdef JT89_WR_SKIP_EN
    logic [9:0] shadow_q [8];
    logic [9:0] head_shadow;
    logic [5:0] hold_shadow_hi;

    assign head_shadow    = shadow_q[head[12:10]];
    assign hold_shadow_hi = shadow_q[hold_q[12:10]][9:4];
    assign skip_data      = (hold_q[9:4] == hold_shadow_hi);

    always_comb begin
        drop = 1'b0;
        if (head[12:10] == 3'b110) begin
            drop = 1'b0;
        end else if (is_tone(head[12:10])) begin
            drop = (head[9:0] == head_shadow);
        end else begin
            drop = (head[3:0] == head_shadow[3:0]);
        end
    end

    // Shadows follow what the PSG has actually been sent.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                if (i == 6)          shadow_q[i] <= 10'h004;
                else if (i % 2 == 1) shadow_q[i] <= 10'h00F;
                else                 shadow_q[i] <= 10'h000;
            end
        end else begin
            if (state_d == StLatch) shadow_q[hold_d[12:10]][3:0] <= nibble(hold_d);
            if (state_d == StData)  shadow_q[hold_q[12:10]][9:4] <= hold_q[9:4];
        end
    end
`else
    assign drop      = 1'b0;
    assign skip_data = 1'b0;
`endif

endmodule

// File: tb/tb_jt89_writer.sv
// Testbench for jt89_writer: randomized and directed commands, expected byte
// strobes queued by a reference model, compared by an independent monitor.
module tb_jt89_writer;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned GAP   = 32;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clken = 1'b0;
    logic       cmd_valid = 1'b0;
    logic [2:0] cmd_reg = 3'd0;
    logic [9:0] cmd_data = 10'd0;
    logic       cmd_ready, wr_n, busy;
    logic [7:0] dout;

    int checks = 0;
    int errors = 0;
    int strobes = 0;
    int clken_mode = 0;  // 0: low, 1: high, 2: random
    int pulses = 0;
    bit prev_low = 1'b0;
    bit first = 1'b1;

    // Expected strobes: bit 8 marks a tone data byte.
    logic [8:0] exp_q [$];
    int sh_lo [8];
    int sh_hi [8];

    jt89_writer #(.DEPTH(DEPTH), .GAP(GAP)) dut (
        .clk       (clk),
        .rst       (rst),
        .clken     (clken),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_reg   (cmd_reg),
        .cmd_data  (cmd_data),
        .wr_n      (wr_n),
        .dout      (dout),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (clken_mode)
                0:       clken = 1'b0;
                1:       clken = 1'b1;
                default: clken = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            sh_lo[i] = (i == 6) ? 4 : ((i % 2 == 1) ? 15 : 0);
            sh_hi[i] = 0;
        end
    endtask

    // PSG byte sequence for one accepted command, from the encoding rules.
    task automatic model_push(input int r, input int d);
        bit tone;
        bit vol;
        int nib;
        int hi;
        tone = (r == 0) || (r == 2) || (r == 4);
        vol  = (r % 2 == 1);
        nib  = (r == 6) ? (d % 8) : (d % 16);
        hi   = d / 16;
`ifdef JT89_WR_SKIP_EN
        if (tone && nib == sh_lo[r] && hi == sh_hi[r]) return;
        if (vol && nib == sh_lo[r]) return;
`endif
        exp_q.push_back({1'b0, 8'(128 + r * 16 + nib)});
        sh_lo[r] = nib;
        if (tone) begin
`ifdef JT89_WR_SKIP_EN
            if (hi == sh_hi[r]) return;
`endif
            exp_q.push_back({1'b1, 8'(hi)});
            sh_hi[r] = hi;
        end
    endtask

    // Monitor: every strobe is checked against the scoreboard and the spacing rules.
    initial begin
        logic [8:0] e;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_low = 1'b0;
                first    = 1'b1;
                pulses   = 0;
            end else if (wr_n === 1'b0) begin
                strobes++;
                check("wr_n_adjacent_low", 32'(prev_low), 0);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_strobe: dout %02h, no byte expected", dout);
                end else begin
                    e = exp_q.pop_front();
                    check("strobe_dout", 32'(dout), 32'(e[7:0]));
                    if (e[8]) begin
                        check("latch_to_data_pulses", pulses, GAP);
                    end else if (!first) begin
                        checks++;
                        if (pulses < GAP) begin
                            errors++;
                            $display("FAIL strobe_spacing: got %0d pulses, need >= %0d",
                                     pulses, GAP);
                        end
                    end
                end
                pulses   = 0;
                first    = 1'b0;
                prev_low = 1'b1;
            end else begin
                prev_low = 1'b0;
                if (clken) pulses++;
            end
        end
    end

    // One offered cycle; entered and left just after a rising edge.
    task automatic push_try(input int r, input int d, output bit acc);
        cmd_valid = 1'b1;
        cmd_reg   = 3'(r);
        cmd_data  = 10'(d);
        @(negedge clk);
        acc = cmd_ready;
        @(posedge clk);
        #1;
        if (acc) model_push(r, d);
    endtask

    task automatic push_cmd(input int r, input int d);
        bit acc;
        int n;
        acc = 1'b0;
        n   = 0;
        while (!acc && n < 5000) begin
            push_try(r, d, acc);
            n++;
        end
        cmd_valid = 1'b0;
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL push_timeout: reg %0d data %0h never accepted", r, d);
        end
    endtask

    task automatic wait_strobes(input int target);
        int n;
        n = 0;
        while (strobes < target && n < 5000) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("wait_strobe_timeout", 32'(strobes >= target), 1);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((busy || exp_q.size() != 0) && n < 5000) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("idle_timeout", 32'(n < 5000), 1);
        check("idle_cmd_ready", 32'(cmd_ready), 1);
        check("idle_wr_n", 32'(wr_n), 1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int s0;
        int n;
        int accepted;
        bit acc;
        int r;
        int d;
        int picks [4];
        picks[0] = 10'h3AB;
        picks[1] = 10'h3A0;
        picks[2] = 10'h005;
        picks[3] = 10'h00F;

        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_wr_n", 32'(wr_n), 1);
        check("reset_dout", 32'(dout), 0);
        check("reset_cmd_ready", 32'(cmd_ready), 1);
        check("reset_busy", 32'(busy), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Tone write and busy release after the trailing wait.
        clken_mode = 1;
        s0 = strobes;
        push_cmd(0, 10'h3AB);
        wait_strobes(s0 + 2);
        n = 0;
        while (busy && n < 1000) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("busy_fall_cycles", n, GAP + 1);
        wait_idle();

        // Single-byte writes: volume 2 and noise control.
        s0 = strobes;
        push_cmd(5, 10'h005);
        push_cmd(6, 10'h005);
        wait_idle();
        check("single_byte_strobes", strobes - s0, 2);

        // Reset while waiting after the tone1 latch byte.
        s0 = strobes;
        push_cmd(2, 10'h012);
        wait_strobes(s0 + 1);
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        exp_q.delete();
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("midrst_wr_n", 32'(wr_n), 1);
        check("midrst_busy", 32'(busy), 0);
        check("midrst_cmd_ready", 32'(cmd_ready), 1);
        s0 = strobes;
        repeat (3 * GAP) @(negedge clk);
        check("midrst_no_data_byte", strobes - s0, 0);
        @(posedge clk);
        #1;

        // Redundant tone writes.
        s0 = strobes;
        push_cmd(0, 10'h3AB);
        push_cmd(0, 10'h3AB);
        push_cmd(0, 10'h3A0);
        wait_idle();
`ifdef JT89_WR_SKIP_EN
        check("skip_strobe_count", strobes - s0, 3);
`else
        check("skip_strobe_count", strobes - s0, 6);
`endif

        // Backpressure with clken stalled: noise writes are never dropped.
        clken_mode = 0;
        @(posedge clk);
        #1;
        accepted = 0;
        for (int k = 0; k < int'(DEPTH) + 2; k++) begin
            push_try(6, k, acc);
            if (acc) accepted++;
        end
        check("bp_accepts", accepted, DEPTH + 1);
        check("bp_cmd_ready_low", 32'(cmd_ready), 0);
        clken_mode = 1;
        push_cmd(6, DEPTH + 1);
        wait_idle();

        // Randomized traffic.
        clken_mode = 2;
        for (int i = 0; i < 60; i++) begin
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk);
                #1;
            end
            r = $urandom_range(0, 7);
            d = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 1023))
                                            : picks[$urandom_range(0, 3)];
            push_cmd(r, d);
        end
        wait_idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
